// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - opcodes, responder states and opcode decode for the SPI flash responder
package spi_flash_pkg;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_JEDEC = 8'h9F;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_PP    = 8'h02;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DOUT, DIN, IGNORE} resp_state_t;

  // While a program is in flight only the status read is honoured.
  function automatic resp_state_t decode_op(input logic [7:0] op, input logic is_busy,
                                            input logic wel_set);
    resp_state_t nxt;
    nxt = IGNORE;
    if (!is_busy || op == OP_RDSR) begin
      case (op)
        OP_RDSR, OP_JEDEC: nxt = DOUT;
        OP_READ:           nxt = ADDR;
        OP_PP:             nxt = wel_set ? ADDR : IGNORE;
        default:           nxt = IGNORE;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// rtl/spi_flash_responder_if.sv - SPI bus between initiator and flash responder
interface spi_flash_responder_if;
  logic sck;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sck, output cs_n, output mosi, input miso, input miso_oe);
  modport slave  (input sck, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-flop synchronizer with single-cycle rise/fall pulses
module spi_sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  // sr[1:0] is the synchronizer, sr[2] the previous synchronized level.
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= {3{INIT}};
    else        sr <= {sr[1:0], din};
  end

  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 serial NOR flash emulator backed by an internal byte array
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          DEPTH       = 4096,
  parameter int          AW          = $clog2(DEPTH),
  parameter int          BUSY_CYCLES = 1000,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  spi_flash_responder_if.slave spi,
  output logic                 busy,
  output logic                 wel
);

  localparam int BW = $clog2(BUSY_CYCLES + 1);

  resp_state_t   state, state_next;
  logic          sck_rise, sck_fall, cs_rise, cs_fall;
  logic [1:0]    mosi_sync;
  logic          mosi_s;
  logic [2:0]    bit_cnt;
  logic [6:0]    shift_in;
  logic [7:0]    byte_in, opcode, out_byte, status, src, jedec_byte, mem_q;
  logic [AW-1:0] addr, addr_full, mem_ra;
  logic [1:0]    addr_byte, jedec_idx;
  logic          cs_active, miso_bit, pp_armed, wrote;
  logic [BW-1:0] busy_cnt;
  logic          rise_v, fall_v, byte_done, addr_done, dout_load, mem_we, mem_re;
  logic [7:0]    mem [DEPTH];

  spi_sync_edge #(.INIT(1'b0)) u_sck (
    .clk(sys_clk), .rst_n(sys_rst_n), .din(spi.sck), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.INIT(1'b1)) u_cs (
    .clk(sys_clk), .rst_n(sys_rst_n), .din(spi.cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  // A chip-select release in the same cycle as an sck edge swallows the edge.
  assign rise_v    = sck_rise & ~cs_rise & (state != IDLE);
  assign fall_v    = sck_fall & ~cs_rise & (state != IDLE);
  assign mosi_s    = mosi_sync[1];
  assign byte_in   = {shift_in, mosi_s};
  assign byte_done = rise_v & (bit_cnt == 3'd7);
  assign addr_full = {addr[AW-2:0], mosi_s};
  assign addr_done = byte_done & (state == ADDR) & (addr_byte == 2'd2);
  assign dout_load = fall_v & (state == DOUT) & (bit_cnt == 3'd0);
  assign status    = {6'b0, wel, busy};
  assign mem_we    = byte_done & (state == DIN);
  assign mem_re    = (addr_done | dout_load) & (opcode == OP_READ);
  assign mem_ra    = addr_done ? addr_full : addr + AW'(1);

  assign spi.miso    = miso_bit;
  assign spi.miso_oe = cs_active;

  always_comb begin
    jedec_byte = 8'h00;
    case (jedec_idx)
      2'd0:    jedec_byte = JEDEC_ID[23:16];
      2'd1:    jedec_byte = JEDEC_ID[15:8];
      2'd2:    jedec_byte = JEDEC_ID[7:0];
      default: jedec_byte = 8'h00;
    endcase
    src = mem_q;
    case (opcode)
      OP_RDSR:  src = status;
      OP_JEDEC: src = jedec_byte;
      default:  src = mem_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_next = CMD;
        CMD:     if (byte_done) state_next = decode_op(byte_in, busy, wel);
        ADDR:    if (addr_done) state_next = (opcode == OP_READ) ? DOUT : DIN;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mosi_sync <= '0;
      bit_cnt   <= '0;
      shift_in  <= '0;
      opcode    <= '0;
      addr      <= '0;
      addr_byte <= '0;
      jedec_idx <= '0;
      out_byte  <= '0;
      cs_active <= 1'b0;
      miso_bit  <= 1'b0;
      pp_armed  <= 1'b0;
      wrote     <= 1'b0;
      wel       <= 1'b0;
      busy      <= 1'b0;
      busy_cnt  <= '0;
    end else begin
      mosi_sync <= {mosi_sync[0], spi.mosi};
      if (busy) begin
        busy_cnt <= busy_cnt - BW'(1);
        if (busy_cnt == BW'(1)) busy <= 1'b0;
      end
      if (cs_fall) cs_active <= 1'b1;
      if (cs_rise) begin
        cs_active <= 1'b0;
        bit_cnt   <= '0;
        addr_byte <= '0;
        jedec_idx <= '0;
        miso_bit  <= 1'b0;
        pp_armed  <= 1'b0;
        wrote     <= 1'b0;
        // An accepted program always drops the latch; only real data starts the busy window.
        if (pp_armed) begin
          wel <= 1'b0;
          if (wrote) begin
            busy     <= 1'b1;
            busy_cnt <= BW'(BUSY_CYCLES);
          end
        end
      end else begin
        if (rise_v) begin
          bit_cnt  <= bit_cnt + 3'd1;
          shift_in <= byte_in[6:0];
          if (state == ADDR) addr <= addr_full;
        end
        if (byte_done && state == CMD) begin
          opcode <= byte_in;
          if (!busy && byte_in == OP_WREN) wel <= 1'b1;
          if (!busy && byte_in == OP_WRDI) wel <= 1'b0;
          if (state_next == ADDR && byte_in == OP_PP) pp_armed <= 1'b1;
        end
        if (byte_done && state == ADDR) addr_byte <= addr_byte + 2'd1;
        if (mem_we) begin
          addr  <= {addr[AW-1:8], addr[7:0] + 8'd1};
          wrote <= 1'b1;
        end
        if (dout_load) begin
          out_byte <= src;
          miso_bit <= src[7];
          if (opcode == OP_READ) addr <= addr + AW'(1);
          if (jedec_idx != 2'd3) jedec_idx <= jedec_idx + 2'd1;
        end else if (fall_v && state == DOUT) begin
          miso_bit <= out_byte[3'd7 - bit_cnt];
        end else if (state != DOUT) begin
          miso_bit <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (mem_we) mem[addr] <= byte_in;
    if (mem_re) mem_q <= mem[mem_ra];
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - directed self-checking bench for spi_flash_responder
module tb_spi_flash_responder;

  localparam int HALF = 6;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic busy, wel;
  int   n_tests = 0;
  int   n_fail  = 0;

  spi_flash_responder_if spi();

  spi_flash_responder dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .spi      (spi),
    .busy     (busy),
    .wel      (wel)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi.mosi = tx[i];
      repeat (HALF) @(negedge sys_clk);
      rx[i] = spi.miso;
      spi.sck = 1'b1;
      repeat (HALF) @(negedge sys_clk);
      spi.sck = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] d;
    spi_bits(b, 8, d);
  endtask

  task automatic recv(output logic [7:0] b);
    spi_bits(8'h00, 8, b);
  endtask

  task automatic start_cmd(input logic [7:0] op);
    spi.cs_n = 1'b0;
    repeat (HALF) @(negedge sys_clk);
    send(op);
  endtask

  task automatic send_addr(input logic [23:0] a);
    send(a[23:16]);
    send(a[15:8]);
    send(a[7:0]);
  endtask

  task automatic end_cmd();
    repeat (HALF) @(negedge sys_clk);
    spi.cs_n = 1'b1;
    repeat (2 * HALF) @(negedge sys_clk);
  endtask

  // Releases cs_n and counts how many cycles busy is seen high (bounded).
  task automatic end_busy(output int n);
    repeat (HALF) @(negedge sys_clk);
    spi.cs_n = 1'b1;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      if (busy) n++;
      else if (n > 0) break;
    end
    repeat (HALF) @(negedge sys_clk);
  endtask

  task automatic wren();
    start_cmd(8'h06);
    end_cmd();
  endtask

  task automatic page_program(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1,
                              input int nbytes, output int busy_len);
    start_cmd(8'h02);
    send_addr(a);
    if (nbytes > 0) send(d0);
    if (nbytes > 1) send(d1);
    end_busy(busy_len);
  endtask

  task automatic read2(input logic [23:0] a, output logic [7:0] b0, output logic [7:0] b1);
    start_cmd(8'h03);
    send_addr(a);
    recv(b0);
    recv(b1);
    end_cmd();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b0, b1, b2, b3;
    int blen;
    sys_rst_n = 1'b0;
    spi.cs_n  = 1'b1;
    spi.sck   = 1'b0;
    spi.mosi  = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_miso", spi.miso, 0);
    check("rst_miso_oe", spi.miso_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wel", wel, 0);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    spi.cs_n = 1'b0;
    repeat (HALF) @(negedge sys_clk);
    check("jedec_oe_active", spi.miso_oe, 1);
    send(8'h9F);
    recv(b0); recv(b1); recv(b2); recv(b3);
    end_cmd();
    check("jedec_b0", b0, 8'hEF);
    check("jedec_b1", b1, 8'h40);
    check("jedec_b2", b2, 8'h18);
    check("jedec_b3", b3, 8'h00);
    check("jedec_oe_idle", spi.miso_oe, 0);

    wren();
    check("wren_wel", wel, 1);
    start_cmd(8'h05);
    recv(b0); recv(b1);
    end_cmd();
    check("rdsr_b0", b0, 8'h02);
    check("rdsr_b1", b1, 8'h02);

    page_program(24'h000010, 8'hA5, 8'h5A, 2, blen);
    check("pp_busy_len", blen, 1000);
    check("pp_wel_clr", wel, 0);
    read2(24'h000010, b0, b1);
    check("rd10_b0", b0, 8'hA5);
    check("rd10_b1", b1, 8'h5A);

    wren();
    page_program(24'h000020, 8'h77, 8'h00, 1, blen);
    page_program(24'h000020, 8'h11, 8'h00, 1, blen);
    check("nowren_busy", blen, 0);
    read2(24'h000020, b0, b1);
    check("nowren_keep", b0, 8'h77);

    wren();
    page_program(24'h000100, 8'hC3, 8'h00, 1, blen);
    wren();
    page_program(24'h0000FF, 8'h01, 8'h02, 2, blen);
    read2(24'h0000FF, b0, b1);
    check("pwrap_ff", b0, 8'h01);
    check("pwrap_100_kept", b1, 8'hC3);
    read2(24'h000000, b0, b1);
    check("pwrap_000", b0, 8'h02);

    wren();
    page_program(24'h000FFF, 8'h9E, 8'h00, 1, blen);
    read2(24'h000FFF, b0, b1);
    check("rwrap_fff", b0, 8'h9E);
    check("rwrap_000", b1, 8'h02);

    wren();
    start_cmd(8'h02);
    send_addr(24'h000010);
    spi_bits(8'hFF, 5, b0);
    end_busy(blen);
    check("abort_busy", blen, 0);
    check("abort_wel", wel, 0);
    read2(24'h000010, b0, b1);
    check("abort_keep", b0, 8'hA5);

    wren();
    start_cmd(8'h02);
    send_addr(24'h000040);
    send(8'h00);
    end_cmd();
    check("gate_busy", busy, 1);
    wren();
    check("gate_wren_ignored", wel, 0);
    start_cmd(8'h05);
    recv(b0);
    end_cmd();
    check("gate_rdsr", b0, 8'h01);

    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("midrst_busy", busy, 0);
    check("midrst_oe", spi.miso_oe, 0);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("midrst_busy_stays", busy, 0);

    wren();
    check("wrdi_pre", wel, 1);
    start_cmd(8'h04);
    end_cmd();
    check("wrdi_wel", wel, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
